imm_gen_pipe: RTL and testbench
===============================

// Module: imm_gen_pipe
// PURPOSE
//  Parametrised, pipelined immediate generator for the 16-bit ISA (opcode = ins[15:12]).
//  Sits between fetch/decode and the ALU operand mux. Accepts one instruction per valid/ready beat
//  and returns a sign-extended XLEN-bit immediate one cycle later.
//  Adds a prefix mode: a PFX instruction latches 12 upper bits that widen the next immediate.
// PARAMETERS
//  XLEN       16  immediate output width; legal range XLEN >= 16
//  ILEN       16  instruction width; opcode is always ins[ILEN-1:ILEN-4]
//  PREFIX_EN  1   1 = opcode 4'b1111 is PFX; 0 = 4'b1111 is treated as a non-immediate opcode
// PORTS
//  clk           in   1     single clock, rising edge
//  rst_n         in   1     asynchronous, active-low reset
//  flush         in   1     synchronous pipeline flush
//  in_valid      in   1     in_ins is valid
//  in_ready      out  1     block accepts in_ins this cycle
//  in_ins        in   ILEN  instruction word
//  out_valid     out  1     result beat valid
//  out_ready     in   1     consumer accepts the result beat
//  out_imm       out  XLEN  immediate
//  out_opcode    out  4     opcode of the instruction that produced the beat
//  out_prefixed  out  1     out_imm was built from a held prefix
//  out_err       out  1     a held prefix was followed by an opcode that has no immediate
// BEHAVIOUR
//  Reset (async, rst_n=0): out_valid=0, out_imm=0, out_opcode=0, out_prefixed=0, out_err=0,
//   prefix register=0, state=IDLE. All outputs are registered.
//  Handshake:
//   - in_ready = !flush && (!out_valid || out_ready).
//   - An input is accepted when in_valid && in_ready.
//   - The output register updates only on an accepted non-PFX input.
//   - out_valid clears when out_ready=1 and no new beat is loaded.
//   - While out_valid=1 && out_ready=0, all out_* signals stay stable.
//  Latency: 1 cycle from acceptance to out_valid; throughput 1 beat per cycle.
//  Native immediate by opcode (raw = unsigned field, s = sign-extend to XLEN):
//   - 0000 LOAD:   s(ins[5:3]); raw = {1'b0, ins[5:3]}
//   - 0001 ALUI:   s(ins[5:3]); raw = {1'b0, ins[5:3]}
//   - 1000 STORE:  s(ins[5:0]); raw = ins[3:0]
//   - 0010 BRANCH: s({ins[5:0], 1'b0}), i.e. a halfword offset; raw = ins[3:0]
//   - any other opcode: imm = 0; this is a valid output beat, not an error unless a prefix is held.
//  Prefix FSM (states IDLE, PFX_HELD):
//   - IDLE + accepted PFX: latch ins[11:0]; go to PFX_HELD; no output beat.
//   - PFX_HELD + accepted PFX: overwrite the latched bits; stay in PFX_HELD; no error.
//   - PFX_HELD + accepted immediate opcode:
//     imm = s({pfx[11:0], raw[3:0]}), sign bit 15; out_prefixed=1; go to IDLE.
//   - PFX_HELD + accepted non-immediate opcode: imm=0, out_err=1, out_prefixed=0; prefix dropped; go to IDLE.
//   - In IDLE, out_prefixed=0 and out_err=0.
//  Flush (sync): clears out_valid, out_prefixed, out_err; state goes to IDLE. flush wins over a same-cycle input.
//  Reset asserted mid-beat or mid-prefix: out_valid drops immediately and the held prefix is lost.
// STRUCTURE
//  SV package imm_gen_pkg holds:
//   - opcode localparams OP_LOAD, OP_ALUI, OP_STORE, OP_BRANCH, OP_PFX;
//   - typedef enum {IDLE, PFX_HELD} pfx_state_t;
//   - the prefix field width PFX_W=12.
//  Sub-module imm_decode (combinational) computes: native imm, raw[3:0], has_imm, is_pfx.
//  The top level holds the FSM, the prefix register and the output/handshake register.
// TESTING (XLEN=16, PREFIX_EN=1, out_ready=1 unless stated)
//  1. LOAD 16'h0028 -> next cycle out_valid=1, out_imm=16'hFFFD, out_opcode=0, out_prefixed=0.
//  2. STORE 16'h803F -> out_imm=16'hFFFF. BRANCH 16'h2021 -> out_imm=16'hFFC2. Sent back-to-back: 2 beats in 2 cycles.
//  3. PFX 16'hFABC, then STORE 16'h8005 -> no beat for the PFX; one beat out_imm=16'hABC5, out_prefixed=1.
//  4. PFX 16'hF123, then 16'h4000 -> out_imm=0, out_err=1, out_prefixed=0.
//     A following LOAD 16'h0028 -> 16'hFFFD with out_err=0.
//  5. Hold out_ready=0 for 3 cycles with a beat pending -> in_ready=0 and out_* stable; on release the next beat flows.
//  6. PFX 16'hFABC, flush, STORE 16'h8005 -> out_imm=16'h0005, out_prefixed=0.
//     Repeat with rst_n pulsed instead of flush -> out_valid drops asynchronously; same result after reset.

Source files
------------

// File: rtl/imm_gen_pkg.sv
// Shared opcodes, prefix width and prefix-FSM state type for the 16-bit ISA immediate generator.
package imm_gen_pkg;
  localparam logic [3:0] OP_LOAD   = 4'b0000;
  localparam logic [3:0] OP_ALUI   = 4'b0001;
  localparam logic [3:0] OP_BRANCH = 4'b0010;
  localparam logic [3:0] OP_STORE  = 4'b1000;
  localparam logic [3:0] OP_PFX    = 4'b1111;

  localparam int PFX_W = 12;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    PFX_HELD = 1'b1
  } pfx_state_t;
endpackage

// File: rtl/imm_decode.sv
// Combinational decode of one instruction: native sign-extended immediate, 4-bit raw field,
// and flags for "opcode carries an immediate" and "instruction is a prefix".
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN      = 16,
  parameter int ILEN      = 16,
  parameter int PREFIX_EN = 1
) (
  input  logic [ILEN-1:0] ins,
  output logic [XLEN-1:0] imm,
  output logic [3:0]      raw,
  output logic            has_imm,
  output logic            is_pfx
);

  logic [3:0]        op_s;
  logic signed [2:0] f3_s;
  logic signed [5:0] f6_s;
  logic signed [6:0] f7_s;
  logic              unused_s;

  assign op_s     = ins[ILEN-1:ILEN-4];
  assign f3_s     = ins[5:3];
  assign f6_s     = ins[5:0];
  assign f7_s     = {ins[5:0], 1'b0};
  assign unused_s = ^ins[ILEN-5:6];

  // Opcode-driven field selection; signed casts perform the sign extension to XLEN.
  always_comb begin
    imm     = '0;
    raw     = 4'h0;
    has_imm = 1'b0;
    is_pfx  = 1'b0;
    case (op_s)
      OP_LOAD, OP_ALUI: begin
        imm     = XLEN'(f3_s);
        raw     = {1'b0, ins[5:3]};
        has_imm = 1'b1;
      end
      OP_STORE: begin
        imm     = XLEN'(f6_s);
        raw     = ins[3:0];
        has_imm = 1'b1;
      end
      OP_BRANCH: begin
        imm     = XLEN'(f7_s);
        raw     = ins[3:0];
        has_imm = 1'b1;
      end
      OP_PFX: begin
        is_pfx = (PREFIX_EN != 0) ? 1'b1 : 1'b0;
      end
      default: begin
        imm = '0;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: one-deep valid/ready output stage plus a prefix FSM
// that widens the next immediate with 12 latched upper bits.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN      = 16,
  parameter int ILEN      = 16,
  parameter int PREFIX_EN = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [ILEN-1:0] in_ins,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [3:0]      out_opcode,
  output logic            out_prefixed,
  output logic            out_err
);

  logic [XLEN-1:0]   nat_imm_s;
  logic [3:0]        raw_s;
  logic              has_imm_s;
  logic              is_pfx_s;
  logic              accept_s;
  logic [3:0]        op_s;
  logic signed [15:0] pfx_cat_s;
  logic [XLEN-1:0]   pfx_imm_s;
  logic [PFX_W-1:0]  pfx_r;
  pfx_state_t        state_r;

  imm_decode #(
    .XLEN      (XLEN),
    .ILEN      (ILEN),
    .PREFIX_EN (PREFIX_EN)
  ) u_decode (
    .ins     (in_ins),
    .imm     (nat_imm_s),
    .raw     (raw_s),
    .has_imm (has_imm_s),
    .is_pfx  (is_pfx_s)
  );

  assign op_s      = in_ins[ILEN-1:ILEN-4];
  assign in_ready  = !flush && (!out_valid || out_ready);
  assign accept_s  = in_valid && in_ready;
  // Prefixed immediate always has its sign bit at bit 15, regardless of XLEN.
  assign pfx_cat_s = {pfx_r, raw_s};
  assign pfx_imm_s = XLEN'(pfx_cat_s);

  // Prefix FSM, prefix register and output stage in one registered process.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_imm      <= '0;
      out_opcode   <= 4'h0;
      out_prefixed <= 1'b0;
      out_err      <= 1'b0;
      pfx_r        <= '0;
      state_r      <= IDLE;
    end else if (flush) begin
      out_valid    <= 1'b0;
      out_prefixed <= 1'b0;
      out_err      <= 1'b0;
      state_r      <= IDLE;
    end else if (accept_s && !is_pfx_s) begin
      out_valid  <= 1'b1;
      out_opcode <= op_s;
      state_r    <= IDLE;
      case (state_r)
        PFX_HELD: begin
          out_imm      <= has_imm_s ? pfx_imm_s : '0;
          out_prefixed <= has_imm_s;
          out_err      <= !has_imm_s;
        end
        default: begin
          out_imm      <= nat_imm_s;
          out_prefixed <= 1'b0;
          out_err      <= 1'b0;
        end
      endcase
    end else if (accept_s) begin
      // Accepting a prefix implies any pending beat was consumed this cycle.
      pfx_r     <= in_ins[PFX_W-1:0];
      state_r   <= PFX_HELD;
      out_valid <= 1'b0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: directed spec scenarios with literal expectations,
// then randomized traffic checked every cycle against an arithmetic reference model.
module tb_imm_gen_pipe;
  localparam int XLEN = 16;
  localparam int ILEN = 16;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [ILEN-1:0] in_ins;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [3:0]      out_opcode;
  logic            out_prefixed;
  logic            out_err;

  imm_gen_pipe #(.XLEN(XLEN), .ILEN(ILEN), .PREFIX_EN(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_ins       (in_ins),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_imm      (out_imm),
    .out_opcode   (out_opcode),
    .out_prefixed (out_prefixed),
    .out_err      (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Reference model state
  bit          m_valid;
  logic [15:0] m_imm;
  logic [3:0]  m_op;
  bit          m_pfxd;
  bit          m_err;
  bit          m_held;
  logic [11:0] m_pfx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Native immediate as a plain integer, from the opcode field rules.
  function automatic void native(input logic [15:0] ins, output int val, output bit has,
                                 output int raw);
    int f;
    has = 1'b1;
    case (ins[15:12])
      4'h0, 4'h1: begin f = int'(ins[5:3]); val = (f >= 4) ? f - 8 : f; raw = f; end
      4'h8: begin f = int'(ins[5:0]); val = (f >= 32) ? f - 64 : f; raw = int'(ins[3:0]); end
      4'h2: begin f = int'(ins[5:0]); val = ((f >= 32) ? f - 64 : f) * 2; raw = int'(ins[3:0]); end
      default: begin val = 0; has = 1'b0; raw = 0; end
    endcase
  endfunction

  function automatic void model_reset();
    m_valid = 1'b0; m_imm = 16'h0000; m_op = 4'h0;
    m_pfxd = 1'b0; m_err = 1'b0; m_held = 1'b0; m_pfx = 12'h000;
  endfunction

  function automatic void model_step(input bit v, input logic [15:0] ins, input bit ordy,
                                     input bit fl);
    int val;
    int raw;
    int pv;
    bit has;
    bit acc;
    acc = v && !fl && (!m_valid || ordy);
    if (fl) begin
      m_valid = 1'b0; m_pfxd = 1'b0; m_err = 1'b0; m_held = 1'b0;
    end else if (acc && ins[15:12] == 4'hF) begin
      m_pfx = ins[11:0]; m_held = 1'b1; m_valid = 1'b0;
    end else if (acc) begin
      native(ins, val, has, raw);
      m_valid = 1'b1;
      m_op = ins[15:12];
      if (m_held && has) begin
        pv = int'(m_pfx) * 16 + raw;
        if (pv >= 32768) pv = pv - 65536;
        m_imm = pv[15:0]; m_pfxd = 1'b1; m_err = 1'b0;
      end else if (m_held) begin
        m_imm = 16'h0000; m_pfxd = 1'b0; m_err = 1'b1;
      end else begin
        m_imm = val[15:0]; m_pfxd = 1'b0; m_err = 1'b0;
      end
      m_held = 1'b0;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
  endfunction

  task automatic compare_outputs();
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    if (m_valid) begin
      chk("out_imm", {16'd0, out_imm}, {16'd0, m_imm});
      chk("out_opcode", {28'd0, out_opcode}, {28'd0, m_op});
      chk("out_prefixed", {31'd0, out_prefixed}, {31'd0, m_pfxd});
      chk("out_err", {31'd0, out_err}, {31'd0, m_err});
    end
  endtask

  // One clock: drive, check in_ready, advance model, check outputs just after the edge.
  task automatic cycle(input bit v, input logic [15:0] ins, input bit ordy, input bit fl);
    @(negedge clk);
    in_valid = v; in_ins = ins; out_ready = ordy; flush = fl;
    #1;
    chk("in_ready", {31'd0, in_ready}, {31'd0, !fl && (!m_valid || ordy)});
    model_step(v, ins, ordy, fl);
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic async_reset();
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_imm", {16'd0, out_imm}, 32'd0);
    chk("rst_out_opcode", {28'd0, out_opcode}, 32'd0);
    chk("rst_out_prefixed", {31'd0, out_prefixed}, 32'd0);
    chk("rst_out_err", {31'd0, out_err}, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic lit(input string name, input logic [15:0] imm, input logic [3:0] op,
                     input bit pf, input bit er);
    chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({name, "_imm"}, {16'd0, out_imm}, {16'd0, imm});
    chk({name, "_op"}, {28'd0, out_opcode}, {28'd0, op});
    chk({name, "_pfx"}, {31'd0, out_prefixed}, {31'd0, pf});
    chk({name, "_err"}, {31'd0, out_err}, {31'd0, er});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ins;
    logic [3:0]  ops [6];
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ins = 16'h0000; out_ready = 1'b1;
    model_reset();
    ops[0] = 4'h0; ops[1] = 4'h1; ops[2] = 4'h8; ops[3] = 4'h2; ops[4] = 4'hF; ops[5] = 4'h4;
    async_reset();

    // Native immediates, back-to-back
    cycle(1'b1, 16'h0028, 1'b1, 1'b0); lit("load", 16'hFFFD, 4'h0, 1'b0, 1'b0);
    cycle(1'b1, 16'h803F, 1'b1, 1'b0); lit("store", 16'hFFFF, 4'h8, 1'b0, 1'b0);
    cycle(1'b1, 16'h2021, 1'b1, 1'b0); lit("branch", 16'hFFC2, 4'h2, 1'b0, 1'b0);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    chk("drain_valid", {31'd0, out_valid}, 32'd0);

    // Prefix widening, then prefix followed by a non-immediate opcode
    cycle(1'b1, 16'hFABC, 1'b1, 1'b0);
    chk("pfx_no_beat", {31'd0, out_valid}, 32'd0);
    cycle(1'b1, 16'h8005, 1'b1, 1'b0); lit("pfx_store", 16'hABC5, 4'h8, 1'b1, 1'b0);
    cycle(1'b1, 16'hF123, 1'b1, 1'b0);
    cycle(1'b1, 16'h4000, 1'b1, 1'b0); lit("pfx_err", 16'h0000, 4'h4, 1'b0, 1'b1);
    cycle(1'b1, 16'h0028, 1'b1, 1'b0); lit("after_err", 16'hFFFD, 4'h0, 1'b0, 1'b0);

    // Backpressure: three stalled cycles then release
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 16'h803F, 1'b0, 1'b0);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      lit("stall_hold", 16'hFFFD, 4'h0, 1'b0, 1'b0);
    end
    cycle(1'b1, 16'h803F, 1'b1, 1'b0); lit("release", 16'hFFFF, 4'h8, 1'b0, 1'b0);

    // Flush drops a held prefix
    cycle(1'b1, 16'hFABC, 1'b1, 1'b0);
    cycle(1'b1, 16'h0028, 1'b1, 1'b1);
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    cycle(1'b1, 16'h8005, 1'b1, 1'b0); lit("post_flush", 16'h0005, 4'h8, 1'b0, 1'b0);

    // Reset mid-beat and mid-prefix
    cycle(1'b1, 16'h0028, 1'b0, 1'b0);
    async_reset();
    cycle(1'b1, 16'hFABC, 1'b1, 1'b0);
    async_reset();
    cycle(1'b1, 16'h8005, 1'b1, 1'b0); lit("post_reset", 16'h0005, 4'h8, 1'b0, 1'b0);

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      ins = 16'($urandom);
      ins[15:12] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : ops[$urandom_range(0, 5)];
      if ($urandom_range(0, 299) == 0) async_reset();
      cycle($urandom_range(0, 9) < 7, ins, $urandom_range(0, 9) < 7,
            $urandom_range(0, 39) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
